// File: rtl/test_sched_pkg.sv
// rtl/test_sched_pkg.sv - shared state encodings and defaults for the test scheduler
package test_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RUN   = 2'd3
    } sched_state_t;

    localparam int TMO_DEFAULT = 16;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - free-running dwell counter with a 1-clk expire pulse at DWELL-1
module dwell_timer #(
    parameter int DWELL = 12000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ena,
    input  logic i_clr,
    output logic o_expire
);

    localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_at_end;

    assign w_at_end = (r_cnt == CW'(DWELL - 1));
    assign o_expire = i_ena && w_at_end;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_ena) begin
            r_cnt <= w_at_end ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/test_scheduler.sv
// rtl/test_scheduler.sv - owns the LED mux select and the serial TX start/busy handshake
module test_scheduler
    import test_sched_pkg::*;
#(
    parameter int NCT   = 4,
    parameter int DWELL = 12000000,
    parameter int TMO   = TMO_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_next,
    input  logic       i_auto,
    input  logic       i_go,
    input  logic       i_tx_busy,
    output logic [1:0] o_sel,
    output logic       o_sel_chg,
    output logic       o_tx_go,
    output logic       o_err
);

    localparam int TW = $clog2(TMO + 1);

    sched_state_t  r_state, w_state_nxt;
    logic [1:0]    r_sel, w_sel_nxt;
    logic          r_sel_chg, w_sel_chg_nxt;
    logic          r_tx_go, w_tx_go_nxt;
    logic          r_err, w_err_nxt;
    logic          r_pending, w_pending_nxt;
    logic [TW-1:0] r_tmo_cnt;

    logic          w_dwell_ena;
    logic          w_dwell_clr;
    logic          w_expire;
    logic          w_adv_src;
    logic          w_advance;
    logic [1:0]    w_sel_inc;

    assign w_dwell_ena = (r_state == ST_IDLE) && i_auto;
    assign w_dwell_clr = w_advance || !w_dwell_ena;
    assign w_adv_src   = i_next || w_expire;
    assign w_sel_inc   = (r_sel == 2'(NCT - 1)) ? 2'd0 : r_sel + 2'd1;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_ena    (w_dwell_ena),
        .i_clr    (w_dwell_clr),
        .o_expire (w_expire)
    );

    // Deferred and fresh advances merge in IDLE; an advance always beats go.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_sel_chg_nxt = 1'b0;
        w_err_nxt     = r_err;
        w_pending_nxt = r_pending;
        w_advance     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending || w_adv_src) begin
                    w_advance     = 1'b1;
                    w_sel_nxt     = w_sel_inc;
                    w_sel_chg_nxt = 1'b1;
                    w_pending_nxt = 1'b0;
                end else if (i_go) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_adv_src) w_pending_nxt = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_adv_src) w_pending_nxt = 1'b1;
                if (i_tx_busy) begin
                    w_state_nxt = ST_RUN;
                end else if (r_tmo_cnt == TW'(TMO - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_adv_src) w_pending_nxt = 1'b1;
                if (!i_tx_busy) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_tx_go_nxt = (w_state_nxt == ST_START);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_sel     <= 2'd0;
            r_sel_chg <= 1'b0;
            r_tx_go   <= 1'b0;
            r_err     <= 1'b0;
            r_pending <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_sel_chg <= w_sel_chg_nxt;
            r_tx_go   <= w_tx_go_nxt;
            r_err     <= w_err_nxt;
            r_pending <= w_pending_nxt;
            r_tmo_cnt <= (r_state == ST_WAIT) ? r_tmo_cnt + 1'b1 : '0;
        end
    end

    assign o_sel     = r_sel;
    assign o_sel_chg = r_sel_chg;
    assign o_tx_go   = r_tx_go;
    assign o_err     = r_err;

endmodule

// File: tb/tb_test_scheduler.sv
// tb/tb_test_scheduler.sv - directed self-checking bench for test_scheduler
module tb_test_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       next_p;
    logic       auto_l;
    logic       go_p;
    logic       tx_busy;
    logic [1:0] sel;
    logic       sel_chg;
    logic       tx_go;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int chg_cnt  = 0;
    int go_cnt   = 0;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_START = 32'd1;
    localparam logic [31:0] S_WAIT  = 32'd2;
    localparam logic [31:0] S_RUN   = 32'd3;

    test_scheduler #(
        .NCT   (4),
        .DWELL (10),
        .TMO   (16)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_next    (next_p),
        .i_auto    (auto_l),
        .i_go      (go_p),
        .i_tx_busy (tx_busy),
        .o_sel     (sel),
        .o_sel_chg (sel_chg),
        .o_tx_go   (tx_go),
        .o_err     (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        chg_cnt += int'(sel_chg);
        go_cnt  += int'(tx_go);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst = 1'b1; next_p = 1'b0; auto_l = 1'b0; go_p = 1'b0; tx_busy = 1'b0;
        cycles(3);
        check_eq("rst_sel", 32'(sel), 32'd0);
        check_eq("rst_sel_chg", 32'(sel_chg), 32'd0);
        check_eq("rst_tx_go", 32'(tx_go), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_state", 32'(dut.r_state), S_IDLE);
        rst = 1'b0;
        cyc();

        // four manual advances with wrap
        for (int k = 1; k <= 4; k++) begin
            chg_cnt = 0;
            next_p = 1'b1;
            cyc();
            next_p = 1'b0;
            check_eq("next_sel", 32'(sel), 32'(k % 4));
            check_eq("next_sel_chg", 32'(sel_chg), 32'd1);
            cycles(99);
            check_eq("next_chg_count", 32'(chg_cnt), 32'd1);
        end

        // normal TX run
        go_cnt = 0;
        go_p = 1'b1;
        cyc();
        go_p = 1'b0;
        check_eq("run_tx_go", 32'(tx_go), 32'd1);
        check_eq("run_start", 32'(dut.r_state), S_START);
        cyc();
        check_eq("run_wait", 32'(dut.r_state), S_WAIT);
        check_eq("run_tx_go_low", 32'(tx_go), 32'd0);
        cycles(2);
        tx_busy = 1'b1;
        cycles(50);
        check_eq("run_run", 32'(dut.r_state), S_RUN);
        tx_busy = 1'b0;
        cyc();
        check_eq("run_idle", 32'(dut.r_state), S_IDLE);
        check_eq("run_go_count", 32'(go_cnt), 32'd1);
        check_eq("run_err", 32'(err), 32'd0);

        // acknowledge timeout
        go_p = 1'b1;
        cyc();
        go_p = 1'b0;
        cyc();
        check_eq("tmo_wait", 32'(dut.r_state), S_WAIT);
        cycles(15);
        check_eq("tmo_still_wait", 32'(dut.r_state), S_WAIT);
        check_eq("tmo_err_early", 32'(err), 32'd0);
        cyc();
        check_eq("tmo_idle", 32'(dut.r_state), S_IDLE);
        check_eq("tmo_err", 32'(err), 32'd1);
        go_p = 1'b1;
        cyc();
        go_p = 1'b0;
        cyc();
        tx_busy = 1'b1;
        cycles(5);
        tx_busy = 1'b0;
        cycles(2);
        check_eq("tmo_err_sticky", 32'(err), 32'd1);
        check_eq("tmo_idle_after_run", 32'(dut.r_state), S_IDLE);

        // advances deferred during RUN collapse into one
        next_p = 1'b1;
        cyc();
        next_p = 1'b0;
        check_eq("defer_sel_start", 32'(sel), 32'd1);
        go_p = 1'b1;
        cyc();
        go_p = 1'b0;
        cyc();
        tx_busy = 1'b1;
        cycles(2);
        check_eq("defer_run", 32'(dut.r_state), S_RUN);
        chg_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            next_p = 1'b1;
            cyc();
            next_p = 1'b0;
            cycles(2);
        end
        check_eq("defer_sel_hold", 32'(sel), 32'd1);
        tx_busy = 1'b0;
        cyc();
        check_eq("defer_idle", 32'(dut.r_state), S_IDLE);
        check_eq("defer_sel_u1", 32'(sel), 32'd1);
        cyc();
        check_eq("defer_sel_u2", 32'(sel), 32'd2);
        check_eq("defer_sel_chg", 32'(sel_chg), 32'd1);
        cycles(3);
        check_eq("defer_chg_count", 32'(chg_cnt), 32'd1);

        // auto advance every DWELL cycles, restart after auto drop
        chg_cnt = 0;
        auto_l = 1'b1;
        cycles(9);
        check_eq("auto_sel_pre1", 32'(sel), 32'd2);
        check_eq("auto_chg_none", 32'(chg_cnt), 32'd0);
        cyc();
        check_eq("auto_sel1", 32'(sel), 32'd3);
        check_eq("auto_chg1", 32'(sel_chg), 32'd1);
        cycles(9);
        check_eq("auto_sel_pre2", 32'(sel), 32'd3);
        cyc();
        check_eq("auto_sel2", 32'(sel), 32'd0);
        check_eq("auto_chg2", 32'(sel_chg), 32'd1);
        auto_l = 1'b0;
        cycles(5);
        auto_l = 1'b1;
        cycles(9);
        check_eq("auto_re_pre", 32'(sel), 32'd0);
        cyc();
        check_eq("auto_re_sel", 32'(sel), 32'd1);
        check_eq("auto_re_chg", 32'(sel_chg), 32'd1);
        auto_l = 1'b0;
        cyc();

        // next beats go in the same cycle
        go_cnt = 0;
        next_p = 1'b1;
        go_p = 1'b1;
        cyc();
        next_p = 1'b0;
        go_p = 1'b0;
        check_eq("collide_sel", 32'(sel), 32'd2);
        check_eq("collide_tx_go", 32'(tx_go), 32'd0);
        cycles(3);
        check_eq("collide_go_count", 32'(go_cnt), 32'd0);
        check_eq("collide_idle", 32'(dut.r_state), S_IDLE);

        // reset mid-RUN
        go_p = 1'b1;
        cyc();
        go_p = 1'b0;
        cyc();
        tx_busy = 1'b1;
        cycles(2);
        check_eq("rstrun_run", 32'(dut.r_state), S_RUN);
        rst = 1'b1;
        cyc();
        check_eq("rstrun_sel", 32'(sel), 32'd0);
        check_eq("rstrun_err", 32'(err), 32'd0);
        check_eq("rstrun_state", 32'(dut.r_state), S_IDLE);
        rst = 1'b0;
        tx_busy = 1'b0;
        cyc();
        check_eq("rstrun_tx_go", 32'(tx_go), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
